// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, sequential issue to a 1-cycle synchronous imem,
// 3-entry {instr, pc} queue with valid/ready output, redirect flush and enable gating.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int unsigned DEPTH = 3;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [INSTR_W-1:0] r_q_instr [DEPTH];
    logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
    logic [1:0]         r_rd_ptr;
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_count;

    logic [2:0] w_used;
    logic       w_issue;
    logic       w_push;
    logic       w_pop;

    function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Queued entries plus the outstanding read act as credits, so a push never finds the queue full.
    assign w_used  = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue = ~reset & enable & ~redirect_valid & (w_used < 3'd3);
    assign w_push  = r_inflight & ~redirect_valid;
    assign w_pop   = (r_count != 2'd0) & out_ready;

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_q_instr[r_rd_ptr];
    assign out_pc    = r_q_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc     <= redirect_pc;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_wr_ptr            <= f_next_ptr(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_next_ptr(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/backpressure, scoreboard of expected {pc, word}
// for streaming, redirect, enable gating and mid-stream reset; second instance checks PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;

    logic        w_imem_en;
    logic [7:0]  w_imem_addr;
    logic [15:0] w_imem_rdata = '0;
    logic        w_out_valid;
    logic [15:0] w_out_instr;
    logic [7:0]  w_out_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) dut_w (
        .clk(clk), .reset(reset), .enable(1'b1),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
    );

    function automatic logic [15:0] word_of(input logic [7:0] a);
        return {8'h00, a} ^ 16'hA500;
    endfunction

    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= word_of(imem_addr);
        if (w_imem_en) w_imem_rdata <= word_of(w_imem_addr);
    end

    int          n_total = 0;
    int          n_pass  = 0;
    int          hs      = 0;
    logic [7:0]  m_pc    = 8'h00;
    logic [7:0]  sb [$];
    logic [7:0]  w_exp   = 8'hFE;
    int          w_left  = 6;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic rst, input logic en, input logic rdy,
                        input logic rv, input logic [7:0] rpc);
        logic [7:0] e;
        @(negedge clk);
        reset = rst; enable = en; out_ready = rdy;
        redirect_valid = rv; redirect_pc = rpc;
        #1;
        if (rst || !en || rv) chk("no_issue_when_gated", {31'd0, imem_en}, 32'd0);
        if (!rst && imem_en === 1'b1) begin
            chk("issue_addr", {24'd0, imem_addr}, {24'd0, m_pc});
            sb.push_back(m_pc);
            m_pc = m_pc + 8'd1;
        end
        if (!rst && out_valid === 1'b1 && rdy) begin
            hs++;
            if (sb.size() == 0) begin
                chk("unexpected_output_pc", {24'd0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_pc", {24'd0, out_pc}, {24'd0, e});
                chk("out_instr", {16'd0, out_instr}, {16'd0, word_of(e)});
            end
        end
        if (rv) begin
            sb.delete();
            m_pc = rpc;
        end
        if (rst) begin
            sb.delete();
            m_pc = 8'h00;
        end
        if (!rst && w_left > 0 && w_out_valid === 1'b1) begin
            chk("wrap_out_pc", {24'd0, w_out_pc}, {24'd0, w_exp});
            chk("wrap_out_instr", {16'd0, w_out_instr}, {16'd0, word_of(w_exp)});
            w_exp = w_exp + 8'd1;
            w_left--;
        end
    endtask

    typedef struct {
        logic       rst, en, rdy;
        logic       exp_en;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs [13];
    int   hs0;

    initial begin
        //         rst   en    rdy   imem_en addr   valid pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 8'h04};

        // Reset, fill to three outstanding under backpressure, then release.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].rdy, 1'b0, 8'h00);
            chk($sformatf("tbl%0d_imem_en", i), {31'd0, imem_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("tbl%0d_imem_addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].exp_addr});
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("tbl%0d_out_pc", i), {24'd0, out_pc}, {24'd0, vecs[i].exp_pc});
            if (i < 4) chk($sformatf("tbl%0d_out_instr", i), {16'd0, out_instr}, 32'd0);
        end

        // Sustained streaming: one instruction per cycle.
        hs0 = hs;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("throughput", hs - hs0, 10);

        // Redirect flush.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("redir_t1_imem_en", {31'd0, imem_en}, 32'd1);
        chk("redir_t1_imem_addr", {24'd0, imem_addr}, 32'h40);
        chk("redir_t1_out_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("redir_t2_out_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("redir_t3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_t3_out_pc", {24'd0, out_pc}, 32'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // Enable gap: in-flight word still delivered, queue drains, no issues.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("gap_inflight_delivered", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("gap_drained", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("reenable_issue", {31'd0, imem_en}, 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // Mid-stream reset with two queued and one in flight.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_out_pc", {24'd0, out_pc}, 32'd0);
        chk("rst_mid_out_instr", {16'd0, out_instr}, 32'd0);
        chk("rst_mid_imem_en", {31'd0, imem_en}, 32'd1);
        chk("rst_mid_imem_addr", {24'd0, imem_addr}, 32'd0);
        hs0 = hs;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rst_mid_handshakes", hs - hs0, 7);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("scoreboard_empty", sb.size(), 0);
        chk("wrap_seen_all", w_left, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
